// File: rtl/bin2bcd_ssd_scan.sv
// bin2bcd_ssd_scan: 8-bit binary to 3-digit BCD converter (double dabble) driving a
// multiplexed active-low 4-digit seven-segment display with optional leading-zero blanking.
module bin2bcd_ssd_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          BLANK_LEAD = 1'b1
) (
  input  logic       clock_in,
  input  logic       clr_n,
  input  logic       load,
  input  logic [7:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] anode,
  output logic [6:0] cathode
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [19:0] TC = 20'(SCAN_DIV - 1);
  state_t      r_state, w_next;
  logic [7:0]  r_sr;
  logic [11:0] r_bcd, w_adj;
  logic [2:0]  r_it;
  logic        r_done;
  logic [3:0]  r_u, r_t, r_h, w_dig;
  logic [19:0] r_cnt;
  logic [1:0]  r_idx;
  logic        w_blank;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_adj = {adj3(r_bcd[11:8]), adj3(r_bcd[7:4]), adj3(r_bcd[3:0])};

  always_ff @(posedge clock_in)
    if (!clr_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (load) w_next = SHIFT;
      end
      SHIFT: if (r_it == 3'd7) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in)
    if (!clr_n) begin
      r_sr   <= '0;
      r_bcd  <= '0;
      r_it   <= '0;
      r_done <= 1'b0;
      r_u    <= '0;
      r_t    <= '0;
      r_h    <= '0;
    end else begin
      r_done <= r_state == DONE;
      if (r_state == IDLE && load) begin
        r_sr  <= bin_in;
        r_bcd <= '0;
        r_it  <= '0;
      end
      if (r_state == SHIFT) begin
        {r_bcd, r_sr} <= {w_adj[10:0], r_sr, 1'b0};
        r_it          <= r_it + 3'd1;
      end
      if (r_state == DONE) begin
        r_u <= r_bcd[3:0];
        r_t <= r_bcd[7:4];
        r_h <= r_bcd[11:8];
      end
    end

  always_ff @(posedge clock_in)
    if (!clr_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == TC) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end

  // Slot 3 is always dark; leading zeros go dark only when blanking is enabled
  assign w_dig   = r_idx == 2'd0 ? r_u : r_idx == 2'd1 ? r_t : r_h;
  assign w_blank = r_idx == 2'd3 ||
                   (BLANK_LEAD && r_idx == 2'd2 && r_h == 4'd0) ||
                   (BLANK_LEAD && r_idx == 2'd1 && r_h == 4'd0 && r_t == 4'd0);
  assign anode    = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  assign cathode  = w_blank ? 7'b1111111 : seg(w_dig);
  assign done     = r_done;
  assign units    = r_u;
  assign tens     = r_t;
  assign hundreds = r_h;
endmodule

// File: tb/tb_bin2bcd_ssd_scan.sv
// tb_bin2bcd_ssd_scan: scoreboard bench; stimulus pushes expected conversions, a
// negedge monitor pops them on done and checks busy, digits and display scanning.
module tb_bin2bcd_ssd_scan;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0, load = 1'b0;
  logic [7:0] bin_in = '0;
  logic       busy0, done0, busy1, done1;
  logic [3:0] u0, t0, h0, an0, u1, t1, h1, an1;
  logic [6:0] ca0, ca1;

  typedef struct {int v; int dcyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, last_rst = -1000, last_acc = -100, busy_until = -1;
  int disp = 0, n_chk = 0, n_fail = 0;
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  bin2bcd_ssd_scan #(.SCAN_DIV(4), .BLANK_LEAD(1'b0)) dut0 (
    .clock_in(clk), .clr_n(clr_n), .load(load), .bin_in(bin_in), .busy(busy0), .done(done0),
    .units(u0), .tens(t0), .hundreds(h0), .anode(an0), .cathode(ca0));

  bin2bcd_ssd_scan #(.SCAN_DIV(1), .BLANK_LEAD(1'b1)) dut1 (
    .clock_in(clk), .clr_n(clr_n), .load(load), .bin_in(bin_in), .busy(busy1), .done(done1),
    .units(u1), .tens(t1), .hundreds(h1), .anode(an1), .cathode(ca1));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int enc(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  task automatic scan_chk(input string nm, input logic [3:0] an, input logic [6:0] ca,
                          input int idx, input bit bl);
    int d;
    bit blank;
    d = idx == 0 ? disp % 10 : idx == 1 ? (disp / 10) % 10 : disp / 100;
    blank = idx == 3 || (bl && idx == 2 && disp < 100) || (bl && idx == 1 && disp < 10);
    chk({nm, "_anode"}, an, blank ? 15 : 15 ^ (1 << idx));
    if (!blank) chk({nm, "_cathode"}, ca, seg_tab[d]);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!clr_n) last_rst = cyc;
  end

  always @(negedge clk) if (last_rst >= 0) begin
    bit exp_done, exp_busy;
    if (last_rst == cyc) disp = 0;
    exp_done = q.size() > 0 && q[0].dcyc == cyc;
    chk("done1", done1, exp_done);
    if (done0) begin
      if (q.size() == 0) chk("done_unexpected", done0, 0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.dcyc);
        disp = e.v;
        chk("result", {h0, t0, u0}, enc(e.v));
      end
    end else if (q.size() > 0 && q[0].dcyc <= cyc) begin
      e = q.pop_front();
      chk("done_missing", done0, 1);
      disp = e.v;
    end
    exp_busy = cyc >= last_acc && cyc <= last_acc + 8 && last_rst < last_acc;
    chk("busy0", busy0, exp_busy);
    chk("busy1", busy1, exp_busy);
    chk("digits0", {h0, t0, u0}, enc(disp));
    chk("digits1", {h1, t1, u1}, enc(disp));
    scan_chk("scan0", an0, ca0, ((cyc - last_rst) / 4) % 4, 1'b0);
    scan_chk("scan1", an1, ca1, (cyc - last_rst) % 4, 1'b1);
  end

  task automatic drive(input logic l, input int v, input logic rn);
    int ed;
    ed = cyc + 1;
    load = l;
    bin_in = 8'(v);
    clr_n = rn;
    if (!rn) begin
      busy_until = -1;
      while (q.size() > 0 && q[$].dcyc >= ed) void'(q.pop_back());
    end else if (l && ed > busy_until) begin
      exp_t x;
      x.v = v & 255;
      x.dcyc = ed + 9;
      q.push_back(x);
      busy_until = ed + 9;
      last_acc = ed;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255), 1'b1);
  endtask

  task automatic convert(input int v, input int gap);
    drive(1'b1, v, 1'b1);
    idle(gap);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 55, 1'b0);
    idle(3);
    convert(255, 12);
    convert(0, 12);
    convert(99, 12);
    convert(100, 12);
    drive(1'b1, 37, 1'b1);
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 200, 1'b1);
    idle(12);
    for (int i = 0; i < 25; i++) drive(1'b1, $urandom_range(0, 255), 1'b1);
    idle(12);
    convert(205, 24);
    convert(7, 16);
    convert(40, 16);
    drive(1'b1, 128, 1'b1);
    idle(3);
    drive(1'b0, 0, 1'b0);
    idle(3);
    convert(128, 14);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 60) != 0);
    drive(1'b0, 0, 1'b0);
    idle(14);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bin2bcd_ssd_scan.md
BIN2BCD_SSD_SCAN -- requirements
Module: bin2bcd_ssd_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles each digit is shown; legal range 1..1048576.
REQ-002 Parameter BLANK_LEAD, default 1, enables leading-zero blanking when 1.
REQ-003 clock_in  in  1  system clock; all state changes on its rising edge.
REQ-004 clr_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 load  in  1  request to convert bin_in; level sampled each cycle.
REQ-006 bin_in  in  8  unsigned binary value, 0..255.
REQ-007 busy  out  1  conversion in progress; load ignored while high.
REQ-008 done  out  1  one-cycle pulse; results valid.
REQ-009 units, tens, hundreds  out  4 each  registered BCD result digits.
REQ-010 anode  out  4  active-low digit enables; anode[0] = units.
REQ-011 cathode  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Function
REQ-012 Converter FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 In IDLE, load=1 SHALL capture bin_in into an 8-bit shift register, clear a 12-bit BCD scratch register and an iteration count, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch nibble >= 5, then shift {scratch, shift register} left one bit.
REQ-015 After exactly 8 SHIFT cycles the FSM SHALL enter DONE.
REQ-016 DONE SHALL last one cycle, load units/tens/hundreds from the scratch register, drive done=1, then return to IDLE.
REQ-017 Latency: if load is accepted at edge k, done SHALL be high in the cycle after edge k+9; result outputs change only at that edge.
REQ-018 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 load while busy=1, including during DONE, SHALL be ignored and SHALL NOT be queued.
REQ-020 load held high SHALL start a new conversion in the first IDLE cycle.
REQ-021 Scan counter SHALL be 20 bits and count 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance a 2-bit digit index 0->1->2->3->0.
REQ-022 Index 0/1/2 SHALL select units/tens/hundreds.
REQ-023 Index 3 SHALL be blank (anode = 1111).
REQ-024 For a non-blank slot, anode SHALL be one-hot low at bit index; otherwise anode = 1111.
REQ-025 With BLANK_LEAD=1: hundreds blank when 0; tens blank when hundreds=0 and tens=0; units never blank.
REQ-026 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibble >9 -> 1111111.
REQ-027 anode/cathode SHALL be decoded from the registered index and the registered result digits only, never from scratch state.
REQ-028 Scanning SHALL run continuously and be unaffected by conversion activity.
REQ-029 Displayed digits SHALL change only when done fires.
REQ-030 With SCAN_DIV=1 the index SHALL advance every cycle.

Reset
REQ-031 clr_n=0 at an edge SHALL force:
- FSM to IDLE;
- busy=0 and done=0;
- units=tens=hundreds=0;
- scan counter and index to 0;
- anode=1110 and cathode=1000000 in the following cycle.
REQ-032 Reset during SHIFT or DONE SHALL abort the conversion; no done pulse SHALL follow.
REQ-033 load coincident with clr_n=0 SHALL be ignored.

Verification
REQ-034 Reset: clr_n=0 for 2 cycles -> busy=0, done=0, digits 0/0/0, anode=1110, cathode=1000000.
REQ-035 Conversion values: load=1 one cycle with bin_in=255 -> busy=1 next cycle, done pulse 9 cycles after accept, hundreds/tens/units=2/5/5.
- Repeat with 0 -> 0/0/0, 99 -> 0/9/9, 100 -> 1/0/0.
REQ-036 Busy rejection: load 37, then load 200 on the third cycle while busy -> exactly one done pulse; result 0/3/7.
REQ-037 Scan sequence: SCAN_DIV=4, BLANK_LEAD=0, value 205 -> repeating sequence, 4 cycles each:
- anode 1110 / cathode 0010010;
- anode 1101 / cathode 1000000;
- anode 1011 / cathode 0100100;
- anode 1111.
REQ-038 Leading-zero blanking: BLANK_LEAD=1, value 7 -> only slot 0 active (anode 1110, cathode 1111000); slots 1-3 show 1111.
- Value 40 -> slots 0 and 1 active; slot 2 blank.
REQ-039 Reset mid-conversion: load 128, clr_n=0 on the 4th SHIFT cycle -> next cycle busy=0, digits 0/0/0, no done pulse.
- A fresh load afterwards converts correctly.
